trap_return_ctrl: RTL and testbench

Trap-return controller: the return-side counterpart of the trap-entry PC-save logic. It keeps a LIFO of saved return PCs and interrupt-enable bits, one entry per trap entry. On an `mret` in EX it flushes IF/ID/EX, redirects fetch to the popped PC, waits for a drain window, then restores the global interrupt enable. It sits between the interrupt controller, the EX stage and the fetch PC mux.

---
 rtl/trap_pkg.sv | 19 +
 rtl/trap_stack.sv | 48 ++++
 rtl/trap_return_ctrl.sv | 123 ++++++++++++
 tb/tb_trap_return_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types for the trap-return controller and its return-PC stack.
package trap_pkg;

   localparam int PC_W  = 32;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REDIR,
      DRAIN
   } ret_state_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pie;
   } trap_entry_t;

endpackage

// File: rtl/trap_stack.sv
// Synchronous LIFO of saved trap entries; top of stack is visible combinationally.
module trap_stack
   import trap_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  trap_entry_t            din,
   output trap_entry_t            dout,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   trap_entry_t   mem [DEPTH];
   logic [AW-1:0] top_idx;

   assign full    = (depth == (AW+1)'(DEPTH));
   assign empty   = (depth == '0);
   assign top_idx = AW'(depth - 1'b1);
   assign dout    = mem[top_idx];

   // NOTE: storage is not reset; only the depth counter defines which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[depth[AW-1:0]] <= din;
      end
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth <= '0;
      end else if (push) begin
         if (!full) begin
            depth <= depth + 1'b1;
         end
      end else if (pop && !empty) begin
         depth <= depth - 1'b1;
      end
   end

endmodule

// File: rtl/trap_return_ctrl.sv
// Trap-return sequencer: pops the saved PC on mret, flushes, redirects fetch,
// drains, then restores the saved interrupt enable.
module trap_return_ctrl
   import trap_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_trap_take,
   input  logic [PC_W-1:0]        i_trap_pc,
   input  logic                   i_mret,
   input  logic                   i_stall,
   input  logic                   i_redirect_ack,
   input  logic                   i_csr_ie_we,
   input  logic                   i_csr_ie_wdata,
   output logic                   o_intr_en,
   output logic                   o_flush_IF,
   output logic                   o_flush_ID,
   output logic                   o_flush_EX,
   output logic                   o_redirect,
   output logic [PC_W-1:0]        o_redirect_pc,
   output logic                   o_busy,
   output logic [$clog2(DEPTH):0] o_depth,
   output logic                   o_overflow,
   output logic                   o_underflow
);

   ret_state_e       state;
   logic [PC_W-1:0]  ret_pc;
   logic             ret_pie;
   logic [CNT_W-1:0] cnt;

   logic        mret_req;
   logic        pop;
   logic        full;
   logic        empty;
   trap_entry_t push_entry;
   trap_entry_t top_entry;

   assign mret_req   = i_mret && !i_stall;
   assign pop        = (state == IDLE) && mret_req && !i_trap_take && !empty;
   assign push_entry = '{pc: i_trap_pc, pie: o_intr_en};

   trap_stack #(
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (i_trap_take),
      .pop   (pop),
      .din   (push_entry),
      .dout  (top_entry),
      .depth (o_depth),
      .full  (full),
      .empty (empty)
   );

   assign o_flush_IF    = (state == FLUSH);
   assign o_flush_ID    = (state == FLUSH);
   assign o_flush_EX    = (state == FLUSH);
   assign o_redirect    = (state == REDIR);
   assign o_busy        = (state != IDLE);
   assign o_redirect_pc = ret_pc;

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         ret_pc      <= '0;
         ret_pie     <= 1'b0;
         cnt         <= '0;
         o_intr_en   <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_trap_take) begin
         // A new trap abandons any return in flight; its mret re-executes later.
         o_intr_en <= 1'b0;
         if (full) begin
            o_overflow <= 1'b1;
         end
         state   <= IDLE;
         ret_pc  <= '0;
         ret_pie <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mret_req && !empty) begin
                  ret_pc  <= top_entry.pc;
                  ret_pie <= top_entry.pie;
                  state   <= FLUSH;
               end else begin
                  if (mret_req) begin
                     o_underflow <= 1'b1;
                  end
                  if (i_csr_ie_we) begin
                     o_intr_en <= i_csr_ie_wdata;
                  end
               end
            end
            FLUSH: state <= REDIR;
            REDIR: begin
               if (i_redirect_ack) begin
                  cnt   <= CNT_W'(DRAIN_CYCLES - 1);
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  o_intr_en <= ret_pie;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_return_ctrl.sv
// Directed bench for trap_return_ctrl (DEPTH=4, DRAIN_CYCLES=2).
module tb_trap_return_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_trap_take = 1'b0;
   logic [31:0] i_trap_pc = '0;
   logic        i_mret = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_redirect_ack = 1'b0;
   logic        i_csr_ie_we = 1'b0;
   logic        i_csr_ie_wdata = 1'b0;
   logic        o_intr_en;
   logic        o_flush_IF;
   logic        o_flush_ID;
   logic        o_flush_EX;
   logic        o_redirect;
   logic [31:0] o_redirect_pc;
   logic        o_busy;
   logic [2:0]  o_depth;
   logic        o_overflow;
   logic        o_underflow;

   int total = 0;
   int bad   = 0;

   trap_return_ctrl #(
      .DEPTH        (4),
      .DRAIN_CYCLES (2)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_trap_take    (i_trap_take),
      .i_trap_pc      (i_trap_pc),
      .i_mret         (i_mret),
      .i_stall        (i_stall),
      .i_redirect_ack (i_redirect_ack),
      .i_csr_ie_we    (i_csr_ie_we),
      .i_csr_ie_wdata (i_csr_ie_wdata),
      .o_intr_en      (o_intr_en),
      .o_flush_IF     (o_flush_IF),
      .o_flush_ID     (o_flush_ID),
      .o_flush_EX     (o_flush_EX),
      .o_redirect     (o_redirect),
      .o_redirect_pc  (o_redirect_pc),
      .o_busy         (o_busy),
      .o_depth        (o_depth),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      cyc();
      cyc();
      i_rst = 1'b0;
   endtask

   task automatic push_pc(input logic [31:0] pc);
      i_trap_take = 1'b1;
      i_trap_pc   = pc;
      cyc();
      i_trap_take = 1'b0;
   endtask

   task automatic csr_ie(input logic v);
      i_csr_ie_we    = 1'b1;
      i_csr_ie_wdata = v;
      cyc();
      i_csr_ie_we = 1'b0;
   endtask

   task automatic ack_and_drain();
      i_redirect_ack = 1'b1;
      cyc();
      i_redirect_ack = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      cyc();
      cyc();
      total++; if ({o_intr_en, o_flush_IF, o_flush_ID, o_flush_EX, o_redirect, o_busy, o_overflow, o_underflow} !== 8'h00) begin bad++; $display("FAIL reset_flags: got %b expected 00000000", {o_intr_en, o_flush_IF, o_flush_ID, o_flush_EX, o_redirect, o_busy, o_overflow, o_underflow}); end
      total++; if (o_depth !== 3'd0) begin bad++; $display("FAIL reset_depth: got %0d expected 0", o_depth); end
      total++; if (o_redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h expected 0", o_redirect_pc); end
      i_rst = 1'b0;
   endtask

   task automatic test_enable_return();
      csr_ie(1'b1);
      total++; if (o_intr_en !== 1'b1) begin bad++; $display("FAIL csr_ie_set: got %b expected 1", o_intr_en); end
      push_pc(32'h100);
      total++; if (o_intr_en !== 1'b0) begin bad++; $display("FAIL push_clears_ie: got %b expected 0", o_intr_en); end
      total++; if (o_depth !== 3'd1) begin bad++; $display("FAIL push_depth: got %0d expected 1", o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      total++; if ({o_flush_IF, o_flush_ID, o_flush_EX, o_busy, o_redirect} !== 5'b11110) begin bad++; $display("FAIL flush_cycle: got %b expected 11110", {o_flush_IF, o_flush_ID, o_flush_EX, o_busy, o_redirect}); end
      total++; if (o_depth !== 3'd0) begin bad++; $display("FAIL pop_depth: got %0d expected 0", o_depth); end
      cyc();
      total++; if ({o_flush_IF, o_redirect} !== 2'b01) begin bad++; $display("FAIL redir_cycle: got %b expected 01", {o_flush_IF, o_redirect}); end
      total++; if (o_redirect_pc !== 32'h100) begin bad++; $display("FAIL redir_pc: got %h expected 100", o_redirect_pc); end
      i_redirect_ack = 1'b1;
      cyc();
      i_redirect_ack = 1'b0;
      total++; if ({o_busy, o_redirect, o_intr_en} !== 3'b100) begin bad++; $display("FAIL drain_first: got %b expected 100", {o_busy, o_redirect, o_intr_en}); end
      cyc();
      total++; if ({o_busy, o_intr_en} !== 2'b10) begin bad++; $display("FAIL drain_second: got %b expected 10", {o_busy, o_intr_en}); end
      cyc();
      total++; if ({o_busy, o_intr_en} !== 2'b01) begin bad++; $display("FAIL ie_restored: got %b expected 01", {o_busy, o_intr_en}); end
   endtask

   task automatic test_nested();
      push_pc(32'h100);
      push_pc(32'h200);
      total++; if (o_depth !== 3'd2) begin bad++; $display("FAIL nested_depth: got %0d expected 2", o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect_pc !== 32'h200 || o_redirect !== 1'b1) begin bad++; $display("FAIL nested_pc1: got %h/%b expected 200/1", o_redirect_pc, o_redirect); end
      ack_and_drain();
      total++; if ({o_busy, o_intr_en, o_depth} !== {2'b00, 3'd1}) begin bad++; $display("FAIL nested_ret1: got busy=%b ie=%b depth=%0d expected 0/0/1", o_busy, o_intr_en, o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect_pc !== 32'h100 || o_redirect !== 1'b1) begin bad++; $display("FAIL nested_pc2: got %h/%b expected 100/1", o_redirect_pc, o_redirect); end
      ack_and_drain();
      total++; if ({o_busy, o_intr_en, o_depth} !== {2'b01, 3'd0}) begin bad++; $display("FAIL nested_ret2: got busy=%b ie=%b depth=%0d expected 0/1/0", o_busy, o_intr_en, o_depth); end
   endtask

   task automatic test_delayed_ack();
      push_pc(32'h440);
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         total++; if ({o_redirect, o_busy} !== 2'b11 || o_redirect_pc !== 32'h440) begin bad++; $display("FAIL hold_redirect[%0d]: got redir=%b busy=%b pc=%h expected 1/1/440", i, o_redirect, o_busy, o_redirect_pc); end
         cyc();
      end
      total++; if (o_redirect !== 1'b1) begin bad++; $display("FAIL no_drain_without_ack: got %b expected 1", o_redirect); end
      ack_and_drain();
      total++; if ({o_busy, o_intr_en} !== 2'b01) begin bad++; $display("FAIL delayed_ret: got %b expected 01", {o_busy, o_intr_en}); end
   endtask

   task automatic test_underflow();
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      total++; if (o_underflow !== 1'b1) begin bad++; $display("FAIL underflow_flag: got %b expected 1", o_underflow); end
      total++; if ({o_flush_IF, o_busy, o_redirect, o_intr_en} !== 4'b0001) begin bad++; $display("FAIL underflow_nop: got %b expected 0001", {o_flush_IF, o_busy, o_redirect, o_intr_en}); end
      cyc();
      total++; if ({o_underflow, o_redirect, o_busy} !== 3'b100) begin bad++; $display("FAIL underflow_sticky: got %b expected 100", {o_underflow, o_redirect, o_busy}); end
   endtask

   task automatic test_overflow();
      push_pc(32'hA0);
      push_pc(32'hB0);
      push_pc(32'hC0);
      push_pc(32'hD0);
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL no_early_overflow: got %b expected 0", o_overflow); end
      push_pc(32'hE0);
      total++; if ({o_overflow, o_intr_en, o_depth} !== {2'b10, 3'd4}) begin bad++; $display("FAIL overflow: got ovf=%b ie=%b depth=%0d expected 1/0/4", o_overflow, o_intr_en, o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect_pc !== 32'hD0) begin bad++; $display("FAIL overflow_top: got %h expected d0", o_redirect_pc); end
      ack_and_drain();
      total++; if ({o_busy, o_intr_en, o_depth} !== {2'b00, 3'd3}) begin bad++; $display("FAIL overflow_ret: got busy=%b ie=%b depth=%0d expected 0/0/3", o_busy, o_intr_en, o_depth); end
   endtask

   task automatic test_trap_during_return();
      do_reset();
      total++; if ({o_overflow, o_underflow, o_depth} !== 5'b0) begin bad++; $display("FAIL flags_cleared: got ovf=%b udf=%b depth=%0d expected 0/0/0", o_overflow, o_underflow, o_depth); end
      csr_ie(1'b1);
      push_pc(32'h120);
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect !== 1'b1) begin bad++; $display("FAIL pre_trap_redir: got %b expected 1", o_redirect); end
      push_pc(32'h300);
      total++; if ({o_redirect, o_busy, o_intr_en} !== 3'b000) begin bad++; $display("FAIL trap_abort: got %b expected 000", {o_redirect, o_busy, o_intr_en}); end
      total++; if (o_depth !== 3'd1) begin bad++; $display("FAIL trap_abort_depth: got %0d expected 1", o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect_pc !== 32'h300) begin bad++; $display("FAIL trap_abort_top: got %h expected 300", o_redirect_pc); end
      ack_and_drain();
      total++; if ({o_busy, o_intr_en, o_depth} !== {2'b00, 3'd0}) begin bad++; $display("FAIL trap_abort_ret: got busy=%b ie=%b depth=%0d expected 0/0/0", o_busy, o_intr_en, o_depth); end
   endtask

   task automatic test_trap_priority();
      push_pc(32'h600);
      i_trap_take = 1'b1;
      i_trap_pc   = 32'h700;
      i_mret      = 1'b1;
      cyc();
      i_trap_take = 1'b0;
      i_mret      = 1'b0;
      total++; if ({o_busy, o_flush_IF, o_depth} !== {2'b00, 3'd2}) begin bad++; $display("FAIL trap_over_mret: got busy=%b flush=%b depth=%0d expected 0/0/2", o_busy, o_flush_IF, o_depth); end
      i_mret = 1'b1;
      cyc();
      i_mret = 1'b0;
      cyc();
      total++; if (o_redirect_pc !== 32'h700) begin bad++; $display("FAIL priority_top: got %h expected 700", o_redirect_pc); end
      ack_and_drain();
      total++; if (o_depth !== 3'd1) begin bad++; $display("FAIL priority_depth: got %0d expected 1", o_depth); end
   endtask

   task automatic test_stall_and_reset();
      i_mret  = 1'b1;
      i_stall = 1'b1;
      cyc();
      total++; if ({o_busy, o_flush_IF, o_underflow, o_depth} !== {3'b000, 3'd1}) begin bad++; $display("FAIL stalled_mret: got busy=%b flush=%b udf=%b depth=%0d expected 0/0/0/1", o_busy, o_flush_IF, o_underflow, o_depth); end
      i_stall = 1'b0;
      cyc();
      i_mret = 1'b0;
      total++; if ({o_flush_EX, o_depth} !== {1'b1, 3'd0}) begin bad++; $display("FAIL unstalled_mret: got flush=%b depth=%0d expected 1/0", o_flush_EX, o_depth); end
      cyc();
      i_redirect_ack = 1'b1;
      cyc();
      i_redirect_ack = 1'b0;
      total++; if ({o_busy, o_redirect} !== 2'b10) begin bad++; $display("FAIL in_drain: got %b expected 10", {o_busy, o_redirect}); end
      i_rst = 1'b1;
      cyc();
      i_rst = 1'b0;
      total++; if ({o_intr_en, o_flush_IF, o_flush_ID, o_flush_EX, o_redirect, o_busy, o_overflow, o_underflow} !== 8'h00) begin bad++; $display("FAIL drain_reset: got %b expected 00000000", {o_intr_en, o_flush_IF, o_flush_ID, o_flush_EX, o_redirect, o_busy, o_overflow, o_underflow}); end
      total++; if (o_redirect_pc !== 32'h0 || o_depth !== 3'd0) begin bad++; $display("FAIL drain_reset_regs: got pc=%h depth=%0d expected 0/0", o_redirect_pc, o_depth); end
      cyc();
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got %b expected 0", o_busy); end
   endtask

   initial begin
      test_reset();
      test_enable_return();
      test_nested();
      test_delayed_ack();
      test_underflow();
      test_overflow();
      test_trap_during_return();
      test_trap_priority();
      test_stall_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
